mem_port_responder: RTL and testbench
=====================================

// Module: mem_port_responder
// PURPOSE
//  Target side of the core's MemPortIo request/response protocol: a word-organised scratchpad memory
//  that serves imem or dmem requests from the 1-stage core.
//  Accepts one request at a time and returns one response per request after a programmable wait.
//  Supports sub-word loads (sign/zero extended) and sub-word stores.
//  Flags misaligned, out-of-range and bad-type accesses with an error response.
// PARAMETERS
//  DEPTH_WORDS  4096     number of 32-bit words; power of two
//  BASE_ADDR    32'h0    byte address of word 0; word-aligned
//  LATENCY      0        extra wait cycles between accept and response, 0..15
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_addr   in   32  byte address
//  req_data   in   32  store data, right-justified
//  req_fcn    in   1   0 = load, 1 = store
//  req_typ    in   3   1 = B, 2 = H, 3 = W, 5 = BU, 6 = HU; others illegal
//  resp_valid out  1   single-cycle response pulse; no back-pressure
//  resp_data  out  32  load result; 0 for stores and errors
//  resp_err   out  1   qualifies resp_valid: access rejected
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_err=0.
//   Memory contents are not reset.
//  After rst deasserts, req_ready rises on the first clk edge.
//  FSM states and transitions:
//   IDLE -> WAIT: req_ready=1. On req_valid&req_ready, latch addr/data/fcn/typ and load wait counter with LATENCY.
//   IDLE -> RESP: taken instead of WAIT when LATENCY=0.
//   WAIT: req_ready=0; counter decrements each cycle; counter==1 -> RESP.
//   RESP: commit/read, drive resp_valid=1 for exactly one cycle, then IDLE.
//  Latency: resp_valid is high exactly LATENCY+1 cycles after the accept edge.
//  Back-to-back: a new request can be accepted the cycle after resp_valid.
//   Maximum throughput is one request per LATENCY+2 cycles.
//  Error checks, on latched fields:
//   - illegal typ
//   - H/HU with addr[0]=1
//   - W with addr[1:0]!=0
//   - (addr-BASE_ADDR) >= 4*DEPTH_WORDS, using an unsigned 32-bit subtract; addr<BASE_ADDR wraps and so errs
//   Any error: resp_err=1, resp_data=0, no memory write.
//  Loads: word index (addr-BASE_ADDR)>>2; lane select by addr[1:0].
//   B/H sign-extend to 32 bits; BU/HU zero-extend; W returns the whole word.
//  Stores: req_data[7:0] or [15:0] written to the addressed byte lanes only; other lanes unchanged.
//   W writes all 4 lanes.
//   The write commits on the clock edge that ends RESP. A load issued afterwards sees the new data.
//  resp_data and resp_err hold their values while resp_valid=0. They update only in RESP.
//  req_* inputs are ignored while req_ready=0. Fields are sampled only on the accept edge.
//  Reset mid-operation: a pending store in WAIT/RESP is dropped (memory unchanged) and no response is issued.
//  Counter width: 4 bits. LATENCY>15 is a parameter error, flagged by an elaboration-time assertion.
// TESTING
//  LATENCY=0: store W 0xDEADBEEF @0x10, then load W @0x10 -> resp_valid 1 cycle after each accept,
//   load data 0xDEADBEEF, resp_err=0.
//  Sub-word store/load: store B 0x80 @0x11, then:
//   load B @0x11 -> 0xFFFFFF80; load BU -> 0x00000080; load W @0x10 -> 0xDEAD80EF.
//  Misaligned: load H @0x13 -> resp_err=1, resp_data=0.
//   Store W @0x12 -> resp_err=1 and word 0x10 unchanged.
//  Range: with DEPTH_WORDS=16 and BASE_ADDR=0x100:
//   load W @0x140 -> err; @0xFC -> err; @0x13C -> ok.
//  LATENCY=3: accept at cycle t -> resp_valid at t+4, req_ready=0 for t+1..t+4;
//   req_valid held high yields the next accept at t+5.
//  Reset: assert rst during WAIT of store W 0x12345678 @0x20 -> no resp_valid; later load @0x20 returns the prior value.

Source files
------------

// File: rtl/mem_port_responder.sv
// ---------------------------------------------------------------------------
// mem_port_responder
//   Target side of the core's MemPortIo request/response protocol: a word-
//   organised scratchpad that serves one request at a time and returns one
//   response per request after LATENCY extra wait cycles.
//
//   Ports
//     clk        clock, all state on the rising edge
//     rst        asynchronous, active-low reset
//     req_valid  request present
//     req_ready  responder can accept a request this cycle
//     req_addr   byte address
//     req_data   store data, right-justified
//     req_fcn    0 = load, 1 = store
//     req_typ    1 = B, 2 = H, 3 = W, 5 = BU, 6 = HU; others illegal
//     resp_valid single-cycle response pulse, no back-pressure
//     resp_data  load result; 0 for stores and errors
//     resp_err   qualifies resp_valid: access rejected
// ---------------------------------------------------------------------------
module mem_port_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LATENCY     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_port_responder: LATENCY must be 0..15");
    end
    if (DEPTH_WORDS < 1 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("mem_port_responder: DEPTH_WORDS must be a power of two");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [2:0] {
        TYP_B = 3'd1, TYP_H = 3'd2, TYP_W = 3'd3, TYP_BU = 3'd5, TYP_HU = 3'd6
    } typ_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] a_addr, a_data;
    logic        a_fcn;
    logic [2:0]  a_typ;

    // NOTE: storage has no reset; its contents are undefined until written.
    logic [31:0] mem [0:(1 << AW) - 1];

    // The response is computed on the edge entering RESP. With LATENCY=0 that
    // edge is the accept edge itself, so in IDLE the live request fields are
    // used; in every other state the latched copy is.
    logic [31:0] s_addr, s_data;
    logic        s_fcn;
    logic [2:0]  s_typ;
    logic [31:0] offset;
    logic [AW-1:0] widx;
    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        err;
    logic [31:0] load_val;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wword;
    logic        accept;

    assign accept = (state == IDLE) && req_ready && req_valid;
    assign s_addr = (state == IDLE) ? req_addr : a_addr;
    assign s_data = (state == IDLE) ? req_data : a_data;
    assign s_fcn  = (state == IDLE) ? req_fcn  : a_fcn;
    assign s_typ  = (state == IDLE) ? req_typ  : a_typ;

    // Unsigned subtract: addresses below BASE_ADDR wrap to huge offsets and
    // so fail the range check too.
    assign offset = s_addr - BASE_ADDR;
    assign widx   = offset[AW+1:2];
    assign word   = mem[widx];
    assign byte_v = 8'(word >> {s_addr[1:0], 3'b000});
    assign half_v = 16'(word >> {s_addr[1], 4'b0000});

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        err      = 1'b0;
        load_val = 32'h0;
        be       = 4'b0000;
        wword    = s_data;
        case (s_typ)
            TYP_B: begin
                load_val = {{24{byte_v[7]}}, byte_v};
                be       = 4'b0001 << s_addr[1:0];
                wword    = {4{s_data[7:0]}};
            end
            TYP_BU: begin
                load_val = {24'h0, byte_v};
                be       = 4'b0001 << s_addr[1:0];
                wword    = {4{s_data[7:0]}};
            end
            TYP_H: begin
                err      = s_addr[0];
                load_val = {{16{half_v[15]}}, half_v};
                be       = s_addr[1] ? 4'b1100 : 4'b0011;
                wword    = {2{s_data[15:0]}};
            end
            TYP_HU: begin
                err      = s_addr[0];
                load_val = {16'h0, half_v};
                be       = s_addr[1] ? 4'b1100 : 4'b0011;
                wword    = {2{s_data[15:0]}};
            end
            TYP_W: begin
                err      = (s_addr[1:0] != 2'b00);
                load_val = word;
                be       = 4'b1111;
            end
            default: err = 1'b1;
        endcase
        if ({1'b0, offset} >= SPAN) err = 1'b1;
        rdata = (err || s_fcn) ? 32'h0 : load_val;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            a_addr     <= 32'h0;
            a_data     <= 32'h0;
            a_fcn      <= 1'b0;
            a_typ      <= 3'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        a_addr    <= req_addr;
                        a_data    <= req_data;
                        a_fcn     <= req_fcn;
                        a_typ     <= req_typ;
                        req_ready <= 1'b0;
                        if (LAT == 4'd0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= rdata;
                            resp_err   <= err;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= rdata;
                        resp_err   <= err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store commits on the edge that ends RESP; a reset forces IDLE first,
    // so an interrupted store never reaches the array.
    always_ff @(posedge clk) begin
        if (state == RESP && a_fcn && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_port_responder
//   Two responders: port 0 (64 words @ 0x0, LATENCY 0) and port 1
//   (16 words @ 0x100, LATENCY 3). A driver issues requests and pushes the
//   reference model's expected response into a per-port queue; a monitor per
//   port pops and compares whenever resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_mem_port_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    localparam logic [2:0] T_B = 3'd1, T_H = 3'd2, T_W = 3'd3, T_BU = 3'd5, T_HU = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_data   [2];
    logic        req_fcn    [2];
    logic [2:0]  req_typ    [2];
    logic        resp_valid [2];
    logic [31:0] resp_data  [2];
    logic        resp_err   [2];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb [2][$];
    logic [31:0] mdl [2][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .req_fcn(req_fcn[0]), .req_typ(req_typ[0]),
        .resp_valid(resp_valid[0]), .resp_data(resp_data[0]), .resp_err(resp_err[0])
    );

    mem_port_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(3)) u1 (
        .clk(clk), .rst(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .req_fcn(req_fcn[1]), .req_typ(req_typ[1]),
        .resp_valid(resp_valid[1]), .resp_data(resp_data[1]), .resp_err(resp_err[1])
    );

    function automatic logic [31:0] base_of(input int p);
        return (p == 1) ? 32'h100 : 32'h0;
    endfunction
    function automatic int depth_of(input int p);
        return (p == 1) ? 16 : 64;
    endfunction
    function automatic int lat_of(input int p);
        return (p == 1) ? 3 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the access rules to a plain word array.
    function automatic exp_t model(input int p, input logic [31:0] a, input logic [31:0] d,
                                   input logic f, input logic [2:0] t);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          lane;
        int          idx;
        off    = a - base_of(p);
        lane   = int'(a[1:0]);
        e.err  = 1'b0;
        e.data = 32'h0;
        case (t)
            T_B, T_BU: ;
            T_H, T_HU: e.err = a[0];
            T_W:       e.err = (lane != 0);
            default:   e.err = 1'b1;
        endcase
        if (off >= 32'(4 * depth_of(p))) e.err = 1'b1;
        if (!e.err) begin
            idx = int'(off / 4);
            w   = mdl[p][idx];
            if (f) begin
                case (t)
                    T_B, T_BU: w[8*lane +: 8]  = d[7:0];
                    T_H, T_HU: w[8*lane +: 16] = d[15:0];
                    default:   w = d;
                endcase
                mdl[p][idx] = w;
            end else begin
                b = w[8*lane +: 8];
                h = w[8*lane +: 16];
                case (t)
                    T_B:     e.data = {{24{b[7]}}, b};
                    T_BU:    e.data = {24'h0, b};
                    T_H:     e.data = {{16{h[15]}}, h};
                    T_HU:    e.data = {16'h0, h};
                    default: e.data = w;
                endcase
            end
        end
        return e;
    endfunction

    // Issue one request. want=0 means no response is expected (reset test).
    task automatic send(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic f, input logic [2:0] t, input bit hold,
                        input bit want, output int acc);
        int n;
        bit got;
        @(negedge clk);
        req_addr[p]  = a;
        req_data[p]  = d;
        req_fcn[p]   = f;
        req_typ[p]   = t;
        req_valid[p] = 1'b1;
        n = 0;
        while (req_ready[p] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[p] !== 1'b1) begin
            check("accept_timeout", {31'h0, req_ready[p]}, 32'h1);
            req_valid[p] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (want) sb[p].push_back(model(p, a, d, f, t));
        if (!hold) req_valid[p] = 1'b0;
        if (want) begin
            n   = 0;
            got = 0;
            while (!got && n < 40) begin
                @(negedge clk);
                n++;
                if (resp_valid[p] === 1'b1) got = 1;
                else check("busy_ready_low", {31'h0, req_ready[p]}, 32'h0);
            end
            check("resp_latency", n, lat_of(p) + 1);
            check("resp_ready_low", {31'h0, req_ready[p]}, 32'h0);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge clk) begin
            if (resp_valid[g] === 1'b1) begin
                exp_t e;
                if (sb[g].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp port %0d: got data %h err %b, expected no response",
                             g, resp_data[g], resp_err[g]);
                end else begin
                    e = sb[g].pop_front();
                    check($sformatf("resp_data_p%0d", g), resp_data[g], e.data);
                    check($sformatf("resp_err_p%0d", g), {31'h0, resp_err[g]}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, acc;
        logic [31:0] a;
        for (int p = 0; p < 2; p++) begin
            rst_n[p]     = 1'b0;
            req_valid[p] = 1'b0;
            req_addr[p]  = 32'h0;
            req_data[p]  = 32'h0;
            req_fcn[p]   = 1'b0;
            req_typ[p]   = 3'd0;
        end
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            check("rst_req_ready", {31'h0, req_ready[p]}, 32'h0);
            check("rst_resp_valid", {31'h0, resp_valid[p]}, 32'h0);
            check("rst_resp_data", resp_data[p], 32'h0);
            check("rst_resp_err", {31'h0, resp_err[p]}, 32'h0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst_p0", {31'h0, req_ready[0]}, 32'h1);
        check("ready_after_rst_p1", {31'h0, req_ready[1]}, 32'h1);

        // Give every word a known value.
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < depth_of(p); i++)
                send(p, base_of(p) + 32'(4 * i), $urandom, 1'b1, T_W, 1'b0, 1'b1, acc);

        // Port 0 directed cases.
        send(0, 32'h10, 32'hDEADBEEF, 1'b1, T_W,  1'b0, 1'b1, acc);
        send(0, 32'h10, 32'h0,        1'b0, T_W,  1'b0, 1'b1, acc);
        send(0, 32'h11, 32'h80,       1'b1, T_B,  1'b0, 1'b1, acc);
        send(0, 32'h11, 32'h0,        1'b0, T_B,  1'b0, 1'b1, acc);
        send(0, 32'h11, 32'h0,        1'b0, T_BU, 1'b0, 1'b1, acc);
        send(0, 32'h10, 32'h0,        1'b0, T_W,  1'b0, 1'b1, acc);
        send(0, 32'h13, 32'h0,        1'b0, T_H,  1'b0, 1'b1, acc);
        send(0, 32'h12, 32'h11223344, 1'b1, T_W,  1'b0, 1'b1, acc);
        send(0, 32'h10, 32'h0,        1'b0, T_W,  1'b0, 1'b1, acc);
        send(0, 32'h12, 32'hA5A5,     1'b1, T_H,  1'b0, 1'b1, acc);
        send(0, 32'h12, 32'h0,        1'b0, T_HU, 1'b0, 1'b1, acc);
        send(0, 32'h10, 32'h0,        1'b0, 3'd4, 1'b0, 1'b1, acc);
        send(0, 32'h10, 32'h0,        1'b0, 3'd7, 1'b0, 1'b1, acc);
        send(0, 32'h100, 32'h0,       1'b0, T_W,  1'b0, 1'b1, acc);

        // Port 1: range edges and back-to-back throughput.
        send(1, 32'h140, 32'h0, 1'b0, T_W, 1'b0, 1'b1, acc);
        send(1, 32'hFC,  32'h0, 1'b0, T_W, 1'b0, 1'b1, acc);
        send(1, 32'h13C, 32'h0, 1'b0, T_W, 1'b1, 1'b1, a1);
        send(1, 32'h100, 32'h0, 1'b0, T_W, 1'b0, 1'b1, a2);
        check("throughput_gap", a2 - a1, lat_of(1) + 2);

        // Port 1: reset during WAIT drops the store and its response.
        send(1, 32'h120, 32'h12345678, 1'b1, T_W, 1'b0, 1'b0, acc);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check("midrst_resp_valid", {31'h0, resp_valid[1]}, 32'h0);
        check("midrst_req_ready", {31'h0, req_ready[1]}, 32'h0);
        repeat (5) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("after_rst_no_resp", {31'h0, resp_valid[1]}, 32'h0);
        send(1, 32'h120, 32'h0, 1'b0, T_W, 1'b0, 1'b1, acc);

        // Randomized traffic on both ports.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 15) == 0)
                    a = base_of(p) - 32'($urandom_range(1, 8));
                else
                    a = base_of(p) + 32'($urandom_range(0, 4 * depth_of(p) + 7));
                send(p, a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'b1, acc);
            end
            @(negedge clk);
            req_valid[p] = 1'b0;
        end

        repeat (8) @(negedge clk);
        check("sb0_drained", sb[0].size(), 32'h0);
        check("sb1_drained", sb[1].size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
